counter_job_arbiter: RTL
========================

COUNTER_JOB_ARBITER -- requirements
Module: counter_job_arbiter

Interface
REQ-001 The block SHALL have a single parameter: STEP_W, default 4, width of the per-job step count.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-low reset.
- req0, req1  in  1  job request from requester 0 and requester 1.
- data0, data1  in  5  job start value.
- mode0, mode1  in  1  job direction: 1 = up, 0 = down.
- steps0, steps1  in  STEP_W  number of count steps after the load.
- count_in  in  5  current count, fed back from the mod-12 counter.
- ctr_load  out  1  counter load strobe.
- ctr_mode  out  1  counter direction.
- ctr_data  out  5  counter load value.
- gnt  out  2  one-hot owner of the counter.
- done  out  2  one-hot job-complete strobe.
- result  out  5  count at job completion.
- busy  out  1  high when the FSM is not IDLE.

Function
REQ-003 The FSM SHALL have four states: IDLE, LOAD, RUN, DONE. All outputs SHALL be decoded from registered state and registered job fields (Moore outputs).
REQ-004 In IDLE with no request pending, the FSM SHALL remain in IDLE.
- Outputs in IDLE: ctr_load=0, ctr_mode=0, ctr_data=0, gnt=0, done=0, busy=0.
REQ-005 Arbitration SHALL be round-robin.
- If exactly one req is high in IDLE, that requester SHALL be granted.
- If both are high, the requester selected by the priority pointer SHALL be granted.
- After each grant, the pointer SHALL move to the other requester.
REQ-006 On a grant in IDLE, the block SHALL latch the granted requester's data, mode and steps, then go to LOAD. Later changes on any job input SHALL be ignored until the next IDLE.
REQ-007 LOAD SHALL last exactly one cycle, with:
- ctr_load=1, ctr_data=latched data, ctr_mode=latched mode;
- next state RUN if latched steps>0, otherwise DONE.
REQ-008 RUN SHALL last exactly latched-steps cycles, with ctr_load=0 and ctr_mode=latched mode.
- An internal down-counter of width STEP_W SHALL track the remaining steps.
- When the last step completes, the FSM SHALL go to DONE.
REQ-009 DONE SHALL last exactly one cycle, with:
- done[g]=1 for the granted requester g;
- result=count_in (only valid while done is high; result=0 otherwise);
- ctr_mode=latched mode, ctr_load=0;
- next state IDLE.
REQ-010 gnt[g] SHALL be high from LOAD through DONE inclusive and low in IDLE. busy SHALL equal (state != IDLE).
REQ-011 Latency: a request granted in IDLE at cycle t SHALL produce done at cycle t+2+steps. At least one IDLE cycle SHALL separate consecutive jobs.
REQ-012 Request handshake:
- req is sampled only in IDLE.
- Dropping req mid-job SHALL NOT abort the job.
- A requester that keeps req high after its done SHALL be eligible again in the next IDLE.
REQ-013 Counter arithmetic belongs to the counter (up wraps at values >=11 to 0; down wraps 0 to 11). The block SHALL NOT compute or check the count; it SHALL only sample count_in in DONE.
REQ-014 Start values 12..31 SHALL be passed to the counter unmodified.

Reset
REQ-015 When rst=0 at a rising edge, the block SHALL enter IDLE and set the pointer to requester 0. All outputs SHALL be 0 and the step counter and latched job fields SHALL be cleared.
REQ-016 A reset during LOAD, RUN or DONE SHALL abort the job without producing a done pulse. The aborted requester SHALL get no priority credit.
REQ-017 Reset SHALL take precedence over every other event in the same cycle.

Verification
REQ-018 Up wrap: req0 with data0=10, mode0=1, steps0=3 -> one LOAD cycle with ctr_data=10, then 3 RUN cycles, then done=01 with result=1, 5 cycles after the grant.
REQ-019 Down wrap: req1 with data1=1, mode1=0, steps1=3 -> done=10 with result=10; gnt=10 held from LOAD through DONE.
REQ-020 Simultaneous requests after reset -> jobs granted in order 0, 1, 0 while both req stay high, each job separated by one IDLE cycle.
REQ-021 steps=0 with data=7 -> LOAD is followed directly by DONE; result=7, done 2 cycles after the grant.
REQ-022 rst=0 asserted during the second RUN cycle -> next cycle is IDLE with all outputs 0 and no done; after reset, a simultaneous req0 and req1 grants requester 0.
REQ-023 req0 dropped during RUN and data0 changed during RUN -> the job completes with the originally latched values and done[0] still pulses.

Source files
------------

// File: rtl/counter_job_arbiter.sv
// Two-requester round-robin arbiter that runs one load/count job on an external mod-12 counter.
// Latency: grant in IDLE at cycle t -> LOAD t+1, RUN for <steps> cycles, done pulse at t+2+steps.
// Backpressure: req is sampled only in IDLE; a busy arbiter simply ignores requests until it returns to IDLE.
module counter_job_arbiter #(
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [4:0]        data0,
  input  logic [4:0]        data1,
  input  logic              mode0,
  input  logic              mode1,
  input  logic [STEP_W-1:0] steps0,
  input  logic [STEP_W-1:0] steps1,
  input  logic [4:0]        count_in,
  output logic              ctr_load,
  output logic              ctr_mode,
  output logic [4:0]        ctr_data,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [4:0]        result,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q;
  logic               ptr_q;        // requester that wins a tie
  logic [4:0]         data_q;       // latched job start value
  logic [STEP_W-1:0]  rem_q;        // remaining RUN cycles
  logic               ctr_load_q;
  logic               ctr_mode_q;   // also the latched job direction
  logic [4:0]         ctr_data_q;
  logic [1:0]         gnt_q;
  logic [1:0]         done_q;
  logic               busy_q;

  // Arbitration decision for the current IDLE cycle
  logic               grant_vld_d;
  logic               grant_sel_d;
  logic [4:0]         sel_data_d;
  logic               sel_mode_d;
  logic [STEP_W-1:0]  sel_steps_d;

  // Round-robin pick: a lone requester wins, a tie goes to the pointer
  always_comb begin
    grant_vld_d = req0 | req1;
    grant_sel_d = 1'b0;
    if (req0 && req1) begin
      grant_sel_d = ptr_q;
    end else if (req1) begin
      grant_sel_d = 1'b1;
    end
    sel_data_d  = grant_sel_d ? data1  : data0;
    sel_mode_d  = grant_sel_d ? mode1  : mode0;
    sel_steps_d = grant_sel_d ? steps1 : steps0;
  end

  // Job FSM; every output is registered alongside the state that owns it
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= 1'b0;
      data_q     <= '0;
      rem_q      <= '0;
      ctr_load_q <= 1'b0;
      ctr_mode_q <= 1'b0;
      ctr_data_q <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_vld_d) begin
            state_q    <= S_LOAD;
            ptr_q      <= ~grant_sel_d;
            data_q     <= sel_data_d;
            rem_q      <= sel_steps_d;
            ctr_load_q <= 1'b1;
            ctr_mode_q <= sel_mode_d;
            ctr_data_q <= sel_data_d;
            gnt_q      <= grant_sel_d ? 2'b10 : 2'b01;
            busy_q     <= 1'b1;
          end
        end

        S_LOAD: begin
          ctr_load_q <= 1'b0;
          ctr_data_q <= '0;
          if (rem_q != '0) begin
            state_q <= S_RUN;
          end else begin
            // Zero-step job: the loaded value is the result
            state_q <= S_DONE;
            done_q  <= gnt_q;
          end
        end

        S_RUN: begin
          rem_q <= rem_q - 1'b1;
          if (rem_q == {{(STEP_W-1){1'b0}}, 1'b1}) begin
            state_q <= S_DONE;
            done_q  <= gnt_q;
          end
        end

        S_DONE: begin
          state_q    <= S_IDLE;
          data_q     <= '0;
          rem_q      <= '0;
          ctr_mode_q <= 1'b0;
          gnt_q      <= '0;
          done_q     <= '0;
          busy_q     <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ctr_load = ctr_load_q;
  assign ctr_mode = ctr_mode_q;
  assign ctr_data = ctr_data_q;
  assign gnt      = gnt_q;
  assign done     = done_q;
  assign busy     = busy_q;

  // The count belongs to the counter; it is only captured while done is high
  assign result   = (done_q != 2'b00) ? count_in : 5'd0;

  // Structural invariants of the job sequencing
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt));
  a_done_owner: assert property (@(posedge clk) disable iff (!rst) (done != 2'b00) |-> (done == gnt));
  a_busy_gnt:   assert property (@(posedge clk) disable iff (!rst) busy == (gnt != 2'b00));
  a_load_owned: assert property (@(posedge clk) disable iff (!rst) ctr_load |-> busy);

endmodule
